// File: rtl/dma_io_pkg.sv
// Shared definitions for the DCNN IO path DMA feeder.
// Contents: bus widths and the writer FSM state encoding.
package dma_io_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        WRITE = ST_WRITE,
        GAP   = ST_GAP,
        FIN   = ST_FIN
    } wr_state_t;

endpackage

// File: rtl/sync_word_fifo.sv
// Small synchronous word FIFO with first-word-fall-through read data.
// Ports:
//   clk, RST        clock, synchronous active-high clear
//   push, wdata     write side; push while full is ignored
//   pop, rdata      read side; rdata shows the head entry, pop while empty ignored
//   full, empty     status from registered pointers
module sync_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indexes match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dma_stream_loader.sv
// Packs an 8-bit valid/ready byte stream into 16-bit words, queues them and
// writes them to consecutive RAM addresses through the DMA write handshake.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | waiting for a queued word; pop it into the address/data registers
// WRITE | dma_write held until dma_done_write is sampled
// GAP   | one idle cycle so the level handshake re-arms
// FIN   | one-cycle done pulse, back to IDLE
//
// Ports:
//   clk, RST                         clock, synchronous active-high reset
//   start, base_addr, word_count     transfer request (honoured in IDLE only)
//   in_valid, in_byte, in_ready      byte stream input
//   dma_address, dma_data, dma_write DMA write request
//   dma_done_write                   DMA write completion
//   busy, done, words_written        transfer status
module dma_stream_loader
    import dma_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit HI_FIRST   = 1'b1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic [ADDR_W-1:0] dma_address,
    output logic [DATA_W-1:0] dma_data,
    output logic              dma_write,
    input  logic              dma_done_write,
    output logic              busy,
    output logic              done,
    output logic [15:0]       words_written
);

    wr_state_t         state;
    wr_state_t         state_nxt;
    logic [16:0]       bytes_left;
    logic              pair_flag;
    logic [BYTE_W-1:0] byte_hold;
    logic [15:0]       count_reg;
    logic [ADDR_W-1:0] next_addr;

    logic              byte_fire;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    assign busy      = (state == LOAD) || (state == WRITE) || (state == GAP);
    // fifo_full is registered state: a pop in this cycle does not open a slot yet.
    assign in_ready  = busy && (bytes_left != '0) && !fifo_full;
    assign byte_fire = in_valid && in_ready;
    assign push      = byte_fire && pair_flag;
    assign push_data = HI_FIRST ? {byte_hold, in_byte} : {in_byte, byte_hold};

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        dma_write = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (word_count != '0) ? LOAD : FIN;
            end
            LOAD: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                dma_write = 1'b1;
                if (dma_done_write) state_nxt = GAP;
            end
            GAP: begin
                state_nxt = (words_written != count_reg) ? LOAD : FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state         <= IDLE;
            bytes_left    <= '0;
            pair_flag     <= 1'b0;
            byte_hold     <= '0;
            count_reg     <= '0;
            next_addr     <= '0;
            words_written <= '0;
            dma_address   <= '0;
            dma_data      <= '0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && start) begin
                count_reg     <= word_count;
                next_addr     <= base_addr;
                words_written <= '0;
                bytes_left    <= {word_count, 1'b0};
                pair_flag     <= 1'b0;
            end

            if (byte_fire) begin
                bytes_left <= bytes_left - 1'b1;
                pair_flag  <= ~pair_flag;
                if (!pair_flag) byte_hold <= in_byte;
            end

            if (pop) begin
                dma_address <= next_addr;
                dma_data    <= fifo_rdata;
            end

            if (state == WRITE && dma_done_write) begin
                words_written <= words_written + 1'b1;
                next_addr     <= next_addr + 1'b1;
            end
        end
    end

endmodule
